// File: rtl/sha2_256_core_if.sv
// Block/digest handshake bundle for the SHA-224/256 compression core.
// master drives blocks in and takes digests out; slave is the core side.
interface sha2_256_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] block_in;
    logic         first;
    logic         mode;
    logic [255:0] digest;
    logic         digest_valid;
    logic         digest_ready;
    logic         busy;

    modport master (
        output in_valid, block_in, first, mode, digest_ready,
        input  in_ready, digest, digest_valid, busy
    );

    modport slave (
        input  in_valid, block_in, first, mode, digest_ready,
        output in_ready, digest, digest_valid, busy
    );
endinterface

// File: rtl/sha2_256_core.sv
// Multi-block SHA-256/SHA-224 compression core, RPC rounds per clock.
// Ports: clk, rst_n (async low), bus (slave: block in, digest out, busy).
module sha2_256_core #(
    parameter int RPC    = 1,
    parameter bit EN_224 = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    sha2_256_core_if.slave  bus
);

    if (!(RPC == 1 || RPC == 2 || RPC == 4)) begin : g_bad_rpc
        $error("sha2_256_core: RPC must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] IV224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] bs0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]}
             ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bs1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]}
             ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(
        input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(
        input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    state_t       state_q, state_d;
    logic         accept, step, finish;
    logic [6:0]   rnd_q;
    logic         mode_q;
    logic [31:0]  w_q  [16];
    logic [31:0]  wk_q [8];
    logic [31:0]  h_q  [8];
    logic [255:0] digest_q;

    logic [31:0]  wa [8];
    logic [31:0]  ww [16];
    logic [31:0]  base [8];
    logic [31:0]  ff [8];
    logic [31:0]  t1, t2, nw;
    logic         sel224;

    assign sel224     = bus.mode && EN_224;
    assign bus.digest = digest_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        accept           = 1'b0;
        step             = 1'b0;
        finish           = 1'b0;
        bus.in_ready     = 1'b0;
        bus.digest_valid = 1'b0;
        bus.busy         = 1'b1;
        unique case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // rnd==64 is a dedicated feed-forward cycle
                if (rnd_q == 7'd64) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                bus.digest_valid = 1'b1;
                if (bus.digest_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Base chaining value selected at accept time
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            base[i] = h_q[i];
            ff[i]   = h_q[i] + wk_q[i];
        end
        if (bus.first) begin
            for (int i = 0; i < 8; i++)
                base[i] = sel224 ? IV224[i] : IV256[i];
        end
    end

    // RPC chained rounds; the window always holds W[t..t+15]
    always_comb begin
        wa = wk_q;
        ww = w_q;
        t1 = '0;
        t2 = '0;
        nw = '0;
        for (int j = 0; j < RPC; j++) begin
            t1 = wa[7] + bs1(wa[4]) + ch(wa[4], wa[5], wa[6])
               + K[rnd_q[5:0] + 6'(j)] + ww[0];
            t2 = bs0(wa[0]) + maj(wa[0], wa[1], wa[2]);
            nw = ss1(ww[14]) + ww[9] + ss0(ww[1]) + ww[0];
            wa[7] = wa[6];
            wa[6] = wa[5];
            wa[5] = wa[4];
            wa[4] = wa[3] + t1;
            wa[3] = wa[2];
            wa[2] = wa[1];
            wa[1] = wa[0];
            wa[0] = t1 + t2;
            for (int i = 0; i < 15; i++) ww[i] = ww[i + 1];
            ww[15] = nw;
        end
    end

    // H takes the base at accept so feed-forward is H + working
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_q    <= '0;
            mode_q   <= 1'b0;
            w_q      <= '{default: '0};
            wk_q     <= '{default: '0};
            h_q      <= '{default: '0};
            digest_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < 16; i++)
                w_q[i] <= bus.block_in[511 - 32 * i -: 32];
            wk_q  <= base;
            h_q   <= base;
            rnd_q <= '0;
            if (bus.first) mode_q <= sel224;
        end else if (step) begin
            wk_q  <= wa;
            w_q   <= ww;
            rnd_q <= rnd_q + 7'(RPC);
        end else if (finish) begin
            h_q <= ff;
            if (mode_q)
                digest_q <= {ff[0], ff[1], ff[2], ff[3],
                             ff[4], ff[5], ff[6], 32'h0};
            else
                digest_q <= {ff[0], ff[1], ff[2], ff[3],
                             ff[4], ff[5], ff[6], ff[7]};
        end
    end

endmodule

// File: doc/sha2_256_core.md
Name: sha2_256_core

Overview:
- Handshaked, multi-block SHA-256/SHA-224 compression engine. It is the successor to the single-block round-iterative core.
- Adds parameterised round unrolling, selection between the SHA-224 and SHA-256 initial values, internal chaining-value retention for multi-block messages, and valid/ready flow control on both input and output.
- Sits between the message padder and the Hash160 top, which feeds its 256-bit result into the RIPEMD-160 stage.

Parameters:
- RPC, default 1: rounds per clock. Legal values are 1, 2, 4. Any other value is an elaboration error.
- EN_224, default 1: when 0, the mode input is ignored and the block runs SHA-256 only.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- in_valid, in, 1: a block is offered on block_in.
- in_ready, out, 1: the core can accept a block.
- block_in, in, 512: padded message block, W0 in bits [511:480].
- first, in, 1: 1 means start a new message from the IV; 0 means chain from the stored H.
- mode, in, 1: 0 selects SHA-256, 1 selects SHA-224. Sampled only when first=1.
- digest, out, 256: chaining value after the last completed block.
- digest_valid, out, 1: digest holds a block result.
- digest_ready, in, 1: consumer accepts digest.
- busy, out, 1: the FSM is not IDLE.

Behaviour:
- Reset values: in_ready=1, digest=0, digest_valid=0, busy=0, FSM=IDLE, H=0, round counter=0, latched mode=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready:
    - Latch block_in into the 16-word W window.
    - Select the base chaining value:
      - first=1: the SHA-256 IV, or the SHA-224 IV (c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4) when mode=1 && EN_224.
      - first=0: the stored H.
    - Load a..h with the selected base. Latch mode when first=1. Set rnd=0 and go to RUN.
- RUN:
  - Each cycle performs RPC chained rounds t=rnd..rnd+RPC-1, with K[t] from a constant table indexed by t.
  - W[t] = M word for t<16. For t≥16, W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16].
  - The W window shifts RPC words per cycle.
  - All additions are mod 2^32, with no carry-out retained.
  - rnd advances by RPC. After the cycle where rnd+RPC==64:
    - Feed-forward: H_i <= base_i + working_i for i=0..7.
    - digest <= {H0..H7} when mode=SHA-256, or {H0..H6, 32'h0} when mode=SHA-224.
    - Set digest_valid=1 and go to DONE.
  - Latency: from the accept edge to digest_valid high is 64/RPC+1 clocks (65, 33, 17).
- DONE:
  - digest_valid=1 and digest is held stable until digest_valid&&digest_ready.
  - On that handshake, clear digest_valid and go to IDLE. H is retained for chaining.
  - in_ready=0 in RUN and in DONE, so no block overlaps a computation. This is intentional.
- Backpressure: digest_ready=0 holds DONE indefinitely. No input is accepted and no state changes.
- first=0 on the first block after reset chains from H=0. This is not an error and needs no special handling.
- A mode change with first=0 is ignored; the latched mode is used.
- Reset mid-RUN or mid-DONE returns immediately to the reset values. The partial result and stored H are discarded.
- in_valid while in_ready=0 is ignored. The upstream must hold its data until in_ready.

Test Plan:
- RPC=1, first=1, mode=0, block="abc" padded (61626380 0…0 00000018) → digest_valid exactly 65 clocks after accept; digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Same block, mode=1 → digest=23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", with first=1 then first=0 → the second digest=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. The first digest must differ.
- Repeat the "abc" and empty-string blocks at RPC=2 and RPC=4 → latency 33 and 17 clocks respectively. The empty-string (80000000 0…0) digest=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Hold digest_ready=0 for 20 cycles in DONE while driving in_valid=1 → digest stable, in_ready=0, no new accept. Release → one-cycle handshake, then IDLE with in_ready=1.
- Assert rst_n=0 at round 30 → all outputs at reset values within the same cycle. A subsequent first=1 "abc" block yields the correct digest.
